// File: rtl/led_matrix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : led_matrix_pkg                                               |
// | Description : Shared types and constants for the LED matrix scanner:       |
// |               scan state encoding, default font contents and a width       |
// |               helper usable in constant expressions.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package led_matrix_pkg;

    // Scan state: a row is blanked first, then driven.
    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam int c_font_glyphs = 4;
    localparam int c_font_rows   = 8;

    // Default 4 x 8 font, 8 columns per row. Entry 0 (glyph 0, row 0) sits in
    // the most significant byte, so the list reads top-down per glyph.
    localparam logic [32*8-1:0] c_font_bits = {
        // glyph 0 : 'A'
        8'h18, 8'h24, 8'h42, 8'h42, 8'h7E, 8'h42, 8'h42, 8'h00,
        // glyph 1 : 'B'
        8'h7C, 8'h42, 8'h42, 8'h7C, 8'h42, 8'h42, 8'h7C, 8'h00,
        // glyph 2 : 'X' frame
        8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81,
        // glyph 3 : nested boxes
        8'hFF, 8'h81, 8'hBD, 8'hA5, 8'hA5, 8'hBD, 8'h81, 8'hFF
    };

    // Ceiling log2, never below 1 so it can size a vector directly.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Font word for (glyph,row). Outside the built-in 4 x 8 table a simple
    // alternating stripe pattern is returned so larger configurations still
    // show something recognisable. Words are at most 64 columns wide.
    function automatic logic [63:0] font_word(input int glyph, input int row);
        int idx;
        idx = glyph * c_font_rows + row;
        if (glyph < c_font_glyphs && row < c_font_rows) begin
            return {56'd0, c_font_bits[(31 - idx) * 8 +: 8]};
        end
        return (((glyph + row) % 2) == 0) ? 64'hAAAA_AAAA_AAAA_AAAA
                                           : 64'h5555_5555_5555_5555;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_font_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : led_font_rom                                                 |
// | Description : GLYPHS*ROWS x COLS font ROM with a one-cycle registered      |
// |               read. Contents come from led_matrix_pkg::font_word.          |
// |   clk       in   1     clock                                               |
// |   i_rd_en   in   1     capture a new word on this edge                     |
// |   i_glyph   in   GW    glyph index (always < GLYPHS)                       |
// |   i_row_idx in   RW    row within the glyph                                |
// |   o_data    out  COLS  word read on the previous enabled edge              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module led_font_rom
    import led_matrix_pkg::*;
#(
    parameter int GLYPHS = 4,
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int GW     = 2,
    parameter int RW     = 3
) (
    input  logic            clk,
    input  logic            i_rd_en,
    input  logic [GW-1:0]   i_glyph,
    input  logic [RW-1:0]   i_row_idx,
    output logic [COLS-1:0] o_data
);

    localparam int c_words = GLYPHS * ROWS;
    localparam int c_aw    = clog2_min1(c_words);

    logic [COLS-1:0] w_rom [c_words];
    logic [c_aw-1:0] w_addr;
    logic [COLS-1:0] r_data;

    for (genvar g = 0; g < GLYPHS; g++) begin : g_glyph
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            localparam logic [63:0] c_word = font_word(g, r);
            assign w_rom[g * ROWS + r] = c_word[COLS-1:0];
        end
    end

    assign w_addr = c_aw'(int'(i_glyph) * ROWS + int'(i_row_idx));

    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_data <= w_rom[w_addr];
        end
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/led_matrix_scanner_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : led_matrix_scanner_p                                         |
// | Description : Row-scanning driver for a ROWS x COLS LED matrix. Each row   |
// |               is blanked for BLANK cycles then driven for DWELL cycles.    |
// |               Glyph and scroll offset change only at frame boundaries.     |
// |   clk        in   1     system clock                                       |
// |   rst        in   1     synchronous reset, active-high                     |
// |   glyph_sel  in   GW    requested glyph (>= GLYPHS shows a blank frame)    |
// |   scroll_en  in   1     advance scroll offset every SCROLL_FRAMES frames   |
// |   scroll_clr in   1     zero the offset at the next frame boundary         |
// |   col        out  COLS  column data, rotated left by the scroll offset     |
// |   row        out  ROWS  one-hot row enable                                 |
// |   frame_done out  1     pulse on the last drive cycle of row ROWS-1        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module led_matrix_scanner_p
    import led_matrix_pkg::*;
#(
    parameter int ROWS          = 8,
    parameter int COLS          = 8,
    parameter int GLYPHS        = 4,
    parameter int DWELL         = 1350,
    parameter int BLANK         = 2,
    parameter int SCROLL_FRAMES = 32,
    localparam int GW           = clog2_min1(GLYPHS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [GW-1:0]   glyph_sel,
    input  logic            scroll_en,
    input  logic            scroll_clr,
    output logic [COLS-1:0] col,
    output logic [ROWS-1:0] row,
    output logic            frame_done
);

    localparam int c_cnt_w = clog2_min1(((DWELL > BLANK) ? DWELL : BLANK) + 1);
    localparam int c_rw    = clog2_min1(ROWS);
    localparam int c_ow    = clog2_min1(COLS);
    localparam int c_fw    = clog2_min1(SCROLL_FRAMES);

    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK - 1);
    localparam logic [c_cnt_w-1:0] c_dwell_last = c_cnt_w'(DWELL - 1);
    localparam logic [c_rw-1:0]    c_row_last   = c_rw'(ROWS - 1);
    localparam logic [c_ow-1:0]    c_off_last   = c_ow'(COLS - 1);
    localparam logic [c_fw-1:0]    c_sf_last    = c_fw'(SCROLL_FRAMES - 1);
    localparam logic [31:0]        c_glyphs_u   = 32'(GLYPHS);
    localparam logic [ROWS-1:0]    c_row_one    = ROWS'(1);

    state_t             r_state, w_state_n;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_n;
    logic [c_rw-1:0]    r_row_idx, w_row_idx_n;
    logic [c_ow-1:0]    r_offset, w_offset_n;
    logic [c_fw-1:0]    r_frame_cnt, w_frame_cnt_n;
    logic [GW-1:0]      r_glyph, w_glyph_n;
    logic               r_blank_frame, w_blank_frame_n;
    logic [COLS-1:0]    r_col;
    logic [ROWS-1:0]    r_row;
    logic               r_frame_done;

    logic               w_boundary;
    logic               w_sel_ok;
    logic               w_rom_rd;
    logic [COLS-1:0]    w_rom_data;
    logic [COLS-1:0]    w_rot;

    // The boundary cycle both latches the new glyph and issues the row-0 ROM
    // read, so the read address uses the glyph being latched, not the old one.
    assign w_boundary = (r_state == ST_BLANK) && (r_cnt == '0) && (r_row_idx == '0);
    assign w_sel_ok   = (32'(glyph_sel) < c_glyphs_u);
    assign w_rom_rd   = (r_state == ST_BLANK) && (r_cnt == '0);

    led_font_rom #(
        .GLYPHS (GLYPHS),
        .ROWS   (ROWS),
        .COLS   (COLS),
        .GW     (GW),
        .RW     (c_rw)
    ) u_rom (
        .clk       (clk),
        .i_rd_en   (w_rom_rd),
        .i_glyph   (w_glyph_n),
        .i_row_idx (r_row_idx),
        .o_data    (w_rom_data)
    );

    // Scan sequencing.
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt + 1'b1;
        w_row_idx_n = r_row_idx;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == c_blank_last) begin
                    w_state_n = ST_DRIVE;
                    w_cnt_n   = '0;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == c_dwell_last) begin
                    w_state_n   = ST_BLANK;
                    w_cnt_n     = '0;
                    w_row_idx_n = (r_row_idx == c_row_last) ? '0 : r_row_idx + 1'b1;
                end
            end
            default: begin
                w_state_n = ST_BLANK;
                w_cnt_n   = '0;
            end
        endcase
    end

    // Frame-boundary updates of glyph and scroll state; clear wins over enable.
    always_comb begin
        w_glyph_n       = r_glyph;
        w_blank_frame_n = r_blank_frame;
        w_offset_n      = r_offset;
        w_frame_cnt_n   = r_frame_cnt;
        if (w_boundary) begin
            w_glyph_n       = w_sel_ok ? glyph_sel : '0;
            w_blank_frame_n = !w_sel_ok;
            if (scroll_clr) begin
                w_offset_n    = '0;
                w_frame_cnt_n = '0;
            end else if (scroll_en) begin
                if (r_frame_cnt == c_sf_last) begin
                    w_frame_cnt_n = '0;
                    w_offset_n    = (r_offset == c_off_last) ? '0 : r_offset + 1'b1;
                end else begin
                    w_frame_cnt_n = r_frame_cnt + 1'b1;
                end
            end
        end
    end

    // Rotate left by the offset: bit i moves to (i + offset) mod COLS.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < COLS; i++) begin
            w_rot[c_ow'((i + int'(r_offset)) % COLS)] = w_rom_data[i];
        end
    end

    // Outputs are registered from next-state values so they line up with the
    // scan state of the same cycle. Column data is captured on entry to DRIVE
    // from the ROM word read during the first BLANK cycle, which needs BLANK
    // of at least 2 for the word to be ready in time.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_BLANK;
            r_cnt         <= '0;
            r_row_idx     <= '0;
            r_offset      <= '0;
            r_frame_cnt   <= '0;
            r_glyph       <= '0;
            r_blank_frame <= 1'b0;
            r_col         <= '0;
            r_row         <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_cnt         <= w_cnt_n;
            r_row_idx     <= w_row_idx_n;
            r_offset      <= w_offset_n;
            r_frame_cnt   <= w_frame_cnt_n;
            r_glyph       <= w_glyph_n;
            r_blank_frame <= w_blank_frame_n;
            if (w_state_n == ST_DRIVE) begin
                r_row <= c_row_one << w_row_idx_n;
                if (r_state == ST_BLANK) begin
                    r_col <= r_blank_frame ? '0 : w_rot;
                end
            end else begin
                r_row <= '0;
                r_col <= '0;
            end
            r_frame_done <= (w_state_n == ST_DRIVE) && (w_row_idx_n == c_row_last)
                            && (w_cnt_n == c_dwell_last);
        end
    end

    assign col        = r_col;
    assign row        = r_row;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scanner_p.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_led_matrix_scanner_p                                      |
// | Description : Scoreboard bench for led_matrix_scanner_p. A frame-level     |
// |               model queues the expected rows at each frame boundary; a     |
// |               monitor pops and compares as rows appear on the outputs.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_led_matrix_scanner_p;

    localparam int ROWS          = 8;
    localparam int COLS          = 8;
    localparam int GLYPHS        = 4;
    localparam int DWELL         = 4;
    localparam int BLANK         = 2;
    localparam int SCROLL_FRAMES = 2;
    localparam int ROW_PERIOD    = BLANK + DWELL;
    localparam int FRAME         = ROWS * ROW_PERIOD;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] glyph_sel;
    logic [1:0] glyph_sel3;
    logic       scroll_en;
    logic       scroll_clr;
    logic [7:0] col, row, col3, row3;
    logic       frame_done, frame_done3;

    always #5 clk = ~clk;

    led_matrix_scanner_p #(
        .ROWS(ROWS), .COLS(COLS), .GLYPHS(GLYPHS), .DWELL(DWELL),
        .BLANK(BLANK), .SCROLL_FRAMES(SCROLL_FRAMES)
    ) u_dut (
        .clk(clk), .rst(rst), .glyph_sel(glyph_sel), .scroll_en(scroll_en),
        .scroll_clr(scroll_clr), .col(col), .row(row), .frame_done(frame_done)
    );

    // Three-glyph instance fed an out-of-range glyph: rows scan, columns stay dark.
    led_matrix_scanner_p #(
        .ROWS(ROWS), .COLS(COLS), .GLYPHS(3), .DWELL(DWELL),
        .BLANK(BLANK), .SCROLL_FRAMES(SCROLL_FRAMES)
    ) u_dut3 (
        .clk(clk), .rst(rst), .glyph_sel(glyph_sel3), .scroll_en(scroll_en),
        .scroll_clr(scroll_clr), .col(col3), .row(row3), .frame_done(frame_done3)
    );

    logic [7:0] font [0:31] = '{
        8'h18, 8'h24, 8'h42, 8'h42, 8'h7E, 8'h42, 8'h42, 8'h00,
        8'h7C, 8'h42, 8'h42, 8'h7C, 8'h42, 8'h42, 8'h7C, 8'h00,
        8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81,
        8'hFF, 8'h81, 8'hBD, 8'hA5, 8'hA5, 8'hBD, 8'h81, 8'hFF
    };

    typedef struct {
        int         start;
        logic [7:0] row;
        logic [7:0] col;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    exp_t mon_e;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int m_glyph  = 0;
    int m_off    = 0;
    int m_fc     = 0;
    bit mon_flush = 1'b0;
    int held      = 0;
    int blank_run = 0;
    int n_rows    = 0;
    logic [7:0] rows3_seen = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
        logic [15:0] d;
        d = {w, w};
        d = d >> (8 - n);
        return d[7:0];
    endfunction

    // Frame-level reference model: at each frame boundary decide glyph and
    // offset, then queue all rows of that frame with their start cycles.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            cyc       = 0;
            m_glyph   = 0;
            m_off     = 0;
            m_fc      = 0;
            mon_flush = 1'b1;
        end else begin
            if (cyc % FRAME == 0) begin
                m_glyph = int'(glyph_sel);
                if (scroll_clr) begin
                    m_off = 0;
                    m_fc  = 0;
                end else if (scroll_en) begin
                    m_fc = m_fc + 1;
                    if (m_fc == SCROLL_FRAMES) begin
                        m_fc  = 0;
                        m_off = (m_off + 1) % COLS;
                    end
                end
                for (int r = 0; r < ROWS; r++) begin
                    m_e.start = cyc + r * ROW_PERIOD + BLANK;
                    m_e.row   = 8'(1 << r);
                    m_e.col   = rotl(font[m_glyph * ROWS + r], m_off);
                    exp_q.push_back(m_e);
                end
            end
            cyc = cyc + 1;
        end
    end

    // Monitor: compares outputs against queued rows, checks gap and dwell.
    always @(negedge clk) begin
        if (mon_flush) begin
            chk("reset_state", {15'd0, frame_done, row, col}, 32'd0);
            mon_flush = 1'b0;
            held      = 0;
            blank_run = 1;
        end else if (row != 8'h00) begin
            if (held == 0) begin
                chk("blank_gap", blank_run, BLANK);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL row_unexpected: got row 0x%0h with no row queued (cycle %0d)", row, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("row_start_cycle", cyc, mon_e.start);
                    n_rows++;
                end
            end
            chk("row_onehot", row, mon_e.row);
            chk("row_col", col, mon_e.col);
            held = held + 1;
            chk("frame_done", frame_done, (row == 8'h80) && (held == DWELL));
            blank_run = 0;
        end else begin
            if (held != 0) begin
                chk("dwell_len", held, DWELL);
            end
            held      = 0;
            blank_run = blank_run + 1;
            chk("idle_state", {15'd0, frame_done, col}, 32'd0);
        end
    end

    always @(negedge clk) begin
        if (!rst && row3 != 8'h00) begin
            chk("blank_glyph_col", col3, 32'd0);
            rows3_seen = rows3_seen | row3;
        end
    end

    task automatic random_inputs();
        if ($urandom_range(0, 15) == 0) glyph_sel = 2'($urandom_range(0, 3));
        scroll_en  = ($urandom_range(0, 3) != 0);
        scroll_clr = ($urandom_range(0, 11) == 0);
    endtask

    initial begin
        rst        = 1'b1;
        glyph_sel  = 2'd1;
        glyph_sel3 = 2'd3;
        scroll_en  = 1'b0;
        scroll_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Glyph request changes mid-frame; the model applies it from frame 1.
        while (cyc < 20) @(negedge clk);
        glyph_sel = 2'd2;
        while (cyc < 3 * FRAME) @(negedge clk);

        // Long scroll so the offset wraps past COLS-1.
        scroll_en = 1'b1;
        while (cyc < 21 * FRAME) @(negedge clk);

        // Clear together with enable.
        scroll_clr = 1'b1;
        while (cyc < 22 * FRAME) @(negedge clk);
        scroll_clr = 1'b0;

        while (cyc < 41 * FRAME) begin
            @(negedge clk);
            random_inputs();
        end

        // Reset while row 3 is being driven.
        for (int k = 0; k < 2 * FRAME && (cyc % FRAME) != 3 * ROW_PERIOD + BLANK + 1; k++) begin
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        while (cyc < 6 * FRAME) begin
            @(negedge clk);
            random_inputs();
        end
        repeat (2) @(negedge clk);

        chk("rows_checked", (n_rows >= 300), 32'd1);
        chk("queue_backlog", (exp_q.size() <= ROWS), 32'd1);
        chk("blank_glyph_rows_scan", rows3_seen, 32'hFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
